// File: rtl/bsg_fifo_1r1w_en_pkg.sv
// Shared helpers for the enable-register FIFO: count width and pointer wrap.
package bsg_fifo_1r1w_en_pkg;

    // Bits needed to hold an occupancy value from 0 to els inclusive.
    function automatic int count_width(input int els);
        return $clog2(els + 1);
    endfunction

    // Advance a ring pointer by one, wrapping from els-1 back to 0.
    function automatic int ptr_inc(input int ptr, input int els);
        return (ptr == els - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_en_dff.sv
// Enable-gated register with no reset; holds its value unless en_i is high.
module bsg_dff_en #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_r;

    // Capture data_i only on cycles where this entry is selected for write.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_r <= data_i;
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/bsg_fifo_1r1w_en.sv
// FIFO of els_p enable-gated registers between a producer and a consumer.
//
// Handshakes: on the input side a word transfers on a rising edge where
// v_i & ready_o; v_i while ready_o is low is simply ignored. On the output
// side the head word leaves on a rising edge where yumi_i is high; yumi_i is
// only legal while v_o is high, and an illegal yumi_i changes nothing.
// There is no bypass: a word written in cycle N appears on data_o in N+1.
module bsg_fifo_1r1w_en
    import bsg_fifo_1r1w_en_pkg::*;
#(
    parameter int  width_p    = 32,
    parameter int  els_p      = 4,
    localparam int lg_els_lp  = $clog2(els_p),
    localparam int count_w_lp = count_width(els_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  v_i,
    input  logic [width_p-1:0]    data_i,
    output logic                  ready_o,
    output logic                  v_o,
    output logic [width_p-1:0]    data_o,
    input  logic                  yumi_i,
    output logic [count_w_lp-1:0] count_o
);

    if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
        $error("bsg_fifo_1r1w_en: els_p must be a power of two and at least 2");
    end
    if (width_p < 1) begin : g_bad_width
        $error("bsg_fifo_1r1w_en: width_p must be at least 1");
    end

    logic [lg_els_lp-1:0]  wptr_r;
    logic [lg_els_lp-1:0]  rptr_r;
    logic [count_w_lp-1:0] count_r;
    logic [lg_els_lp-1:0]  wptr_next;
    logic [lg_els_lp-1:0]  rptr_next;
    logic                  enq;
    logic                  deq;
    logic [width_p-1:0]    mem [els_p];

    // Flags come straight off the registered count so they never glitch.
    assign v_o     = (count_r != '0);
    assign ready_o = (count_r != count_w_lp'(els_p));
    assign count_o = count_r;

    // Only accepted transfers move state; a yumi_i without v_o is dropped.
    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    assign wptr_next = lg_els_lp'(ptr_inc(32'(wptr_r), els_p));
    assign rptr_next = lg_els_lp'(ptr_inc(32'(rptr_r), els_p));

    // Storage: one register per entry, enabled only when it is the write target.
    for (genvar i = 0; i < els_p; i++) begin : g_entry
        bsg_dff_en #(.width_p(width_p)) entry (
            .clk_i  (clk_i),
            .en_i   (enq && (wptr_r == lg_els_lp'(i))),
            .data_i (data_i),
            .data_o (mem[i])
        );
    end

    // Head of queue is a plain combinational read at the read pointer.
    always_comb begin
        data_o = mem[rptr_r];
    end

    // Pointer pair and up/down occupancy count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) begin
                wptr_r <= wptr_next;
            end
            if (deq) begin
                rptr_r <= rptr_next;
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + count_w_lp'(1);
                2'b01:   count_r <= count_r - count_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_fifo_1r1w_en.sv
// Self-checking bench for bsg_fifo_1r1w_en using a queue-based reference model.
module tb_bsg_fifo_1r1w_en;

    localparam int W   = 32;
    localparam int ELS = 4;
    localparam int CW  = $clog2(ELS + 1);

    logic          clk_i;
    logic          reset_n_i;
    logic          v_i;
    logic [W-1:0]  data_i;
    logic          ready_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          yumi_i;
    logic [CW-1:0] count_o;

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;

    bsg_fifo_1r1w_en #(.width_p(W), .els_p(ELS)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i),
        .count_o   (count_o)
    );

    // Clock generation.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Consumer protocol: yumi_i may only be driven while v_o is high.
    always @(negedge clk_i) begin
        if (reset_n_i && yumi_i) begin
            check("yumi_legal", W'(v_o), W'(1));
        end
    end

    // Compare every observable output with the reference queue.
    task automatic check_outputs(input string tag);
        check({tag, "_count"}, W'(count_o), W'(exp_q.size()));
        check({tag, "_v"}, W'(v_o), W'(exp_q.size() != 0));
        check({tag, "_ready"}, W'(ready_o), W'(exp_q.size() != ELS));
        if (exp_q.size() != 0) begin
            check({tag, "_data"}, data_o, exp_q[0]);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the fifo rules, then check.
    task automatic step(input logic v, input logic [W-1:0] d, input logic y, input string tag);
        bit do_enq;
        bit do_deq;
        v_i    = v;
        data_i = d;
        yumi_i = y;
        do_enq = v && (exp_q.size() < ELS);
        do_deq = y && (exp_q.size() > 0);
        @(posedge clk_i);
        #1;
        if (do_deq) void'(exp_q.pop_front());
        if (do_enq) exp_q.push_back(d);
        v_i    = 1'b0;
        yumi_i = 1'b0;
        data_i = $urandom;
        check_outputs(tag);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        v_i       = 1'b0;
        yumi_i    = 1'b0;
        data_i    = '0;
        reset_n_i = 1'b0;

        // Reset state.
        #1;
        check_outputs("reset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        check_outputs("post_reset");

        // Fill back to back; a fifth offer is ignored while full.
        for (int i = 0; i < ELS; i++) begin
            step(1'b1, W'(32'hA0 + i), 1'b0, "fill");
        end
        check("full_count", W'(count_o), W'(4));
        check("full_ready", W'(ready_o), W'(0));
        step(1'b1, W'(32'hFF), 1'b0, "full_ignore");
        check("full_hold_count", W'(count_o), W'(4));
        check("full_head", data_o, W'(32'hA0));

        // Drain one per cycle; head order A0..A3.
        for (int i = 0; i < ELS; i++) begin
            check("drain_head", data_o, W'(32'hA0 + i));
            step(1'b0, '0, 1'b1, "drain");
            if (i == 0) check("drain_ready_back", W'(ready_o), W'(1));
        end
        check("empty_v", W'(v_o), W'(0));
        check("empty_count", W'(count_o), W'(0));

        // Two queued, then six simultaneous enqueue+dequeue cycles across the wrap.
        step(1'b1, W'(32'h10), 1'b0, "pair_fill");
        step(1'b1, W'(32'h11), 1'b0, "pair_fill");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, W'(32'h12 + i), 1'b1, "simul");
            check("simul_count", W'(count_o), W'(2));
            check("simul_head", data_o, W'(32'h11 + i));
        end
        step(1'b0, '0, 1'b1, "simul_drain");
        step(1'b0, '0, 1'b1, "simul_drain");

        // No bypass: v_o stays low in the enqueue cycle.
        v_i    = 1'b1;
        data_i = W'(32'h55);
        #1;
        check("no_bypass_v", W'(v_o), W'(0));
        step(1'b1, W'(32'h55), 1'b0, "bypass");
        check("bypass_next_data", data_o, W'(32'h55));
        step(1'b0, '0, 1'b1, "bypass_drain");

        // Reset mid-operation, asserted away from any clock edge.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, W'(32'h30 + i), 1'b0, "prefill");
        end
        #2;
        reset_n_i = 1'b0;
        exp_q.delete();
        #1;
        check_outputs("async_reset");
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        check_outputs("after_reset");
        step(1'b1, W'(32'h77), 1'b0, "first_after_reset");
        check("first_after_reset_data", data_o, W'(32'h77));

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic y;
            v = ($urandom_range(0, 99) < 60);
            y = (exp_q.size() != 0) && ($urandom_range(0, 99) < 50);
            step(v, W'($urandom), y, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
